// File: rtl/dht_pkg.sv
// Shared types and frame layout for the DHT22 single-wire receiver.
// Frame is {RH[15:0], T[15:0], CKS[7:0]}, transmitted MSB first.
package dht_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START_LOW,
    RELEASE,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK,
    HOLDOFF
  } dht_state_t;

  localparam int FRAME_W = 40;
  localparam int RH_MSB  = 39;
  localparam int RH_LSB  = 24;
  localparam int T_MSB   = 23;
  localparam int T_LSB   = 8;
  localparam int CKS_MSB = 7;
  localparam int CKS_LSB = 0;

  // Modulo-256 sum of the four data bytes; compared against the CKS field.
  function automatic logic [7:0] frame_sum(input logic [FRAME_W-1:0] f);
    return f[RH_MSB -: 8] + f[RH_LSB +: 8] + f[T_MSB -: 8] + f[T_LSB +: 8];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; reset value is
// selectable so idle-high lines do not produce a false edge out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dht22_frame_rx.sv
// DHT22 frame receiver: issues the host start pulse, times the sensor reply
// and 40 data pulses, and keeps the last checksum-valid frame.
//
// state     | meaning
// IDLE      | waiting for trigger, pin released
// START_LOW | host drives the pin low for the start pulse
// RELEASE   | pin released, waiting for the sensor to pull low
// RESP_LOW  | sensor response low phase
// RESP_HIGH | sensor response high phase
// BIT_LOW   | low gap preceding a data bit
// BIT_HIGH  | timing the data bit's high pulse
// CHECK     | verify checksum, publish or flag the frame
// HOLDOFF   | enforced quiet time before the next read
module dht22_frame_rx
  import dht_pkg::*;
#(
  parameter int CYC_PER_US    = 1,
  parameter int START_LOW_US  = 1000,
  parameter int BIT_THRESH_US = 50,
  parameter int TIMEOUT_US    = 200,
  parameter int HOLDOFF_US    = 2000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               trigger,
  input  logic               dht_in,
  output logic               dht_drive_low,
  output logic [FRAME_W-1:0] dht_data,
  output logic               data_valid,
  output logic               checksum_err,
  output logic               timeout_err,
  output logic               busy
);

  localparam int START_CYC = START_LOW_US * CYC_PER_US;
  localparam int THR_CYC   = BIT_THRESH_US * CYC_PER_US;
  localparam int TMO_CYC   = TIMEOUT_US * CYC_PER_US;
  localparam int HOLD_CYC  = HOLDOFF_US * CYC_PER_US;
  localparam int BIG_CYC   = (START_CYC > HOLD_CYC) ? START_CYC : HOLD_CYC;
  localparam int CNT_MAX   = (BIG_CYC > TMO_CYC) ? BIG_CYC : TMO_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX) + 1;

  dht_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [5:0]         bit_idx;
  logic [FRAME_W-1:0] shift;
  logic               pin_s;
  logic               pin_d;
  logic               rise;
  logic               fall;
  logic               sensor_phase;
  logic               edge_seen;
  logic               tmo_hit;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_dht (
    .clk  (clk),
    .rst_n(reset),
    .d    (dht_in),
    .q    (pin_s)
  );

  assign rise    = ~pin_d & pin_s;
  assign fall    = pin_d & ~pin_s;
  assign tmo_hit = (cnt == CNT_W'(TMO_CYC - 1));

  always_comb begin
    sensor_phase = 1'b0;
    edge_seen    = 1'b0;
    case (state)
      RELEASE, RESP_HIGH, BIT_HIGH: begin
        sensor_phase = 1'b1;
        edge_seen    = fall;
      end
      RESP_LOW, BIT_LOW: begin
        sensor_phase = 1'b1;
        edge_seen    = rise;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      pin_d         <= 1'b1;
      dht_drive_low <= 1'b0;
      dht_data      <= '0;
      data_valid    <= 1'b0;
      checksum_err  <= 1'b0;
      timeout_err   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      data_valid   <= 1'b0;
      checksum_err <= 1'b0;
      timeout_err  <= 1'b0;
      pin_d        <= pin_s;
      cnt          <= cnt + CNT_W'(1);

      if (sensor_phase && !edge_seen && tmo_hit) begin
        timeout_err <= 1'b1;
        shift       <= '0;
        state       <= HOLDOFF;
        cnt         <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (trigger) begin
              state         <= START_LOW;
              dht_drive_low <= 1'b1;
              busy          <= 1'b1;
              shift         <= '0;
            end
          end
          START_LOW: begin
            if (cnt == CNT_W'(START_CYC - 1)) begin
              state         <= RELEASE;
              dht_drive_low <= 1'b0;
              cnt           <= '0;
            end
          end
          RELEASE: begin
            if (fall) begin
              state <= RESP_LOW;
              cnt   <= '0;
            end
          end
          RESP_LOW: begin
            if (rise) begin
              state <= RESP_HIGH;
              cnt   <= '0;
            end
          end
          RESP_HIGH: begin
            if (fall) begin
              state   <= BIT_LOW;
              bit_idx <= 6'd39;
              cnt     <= '0;
            end
          end
          BIT_LOW: begin
            if (rise) begin
              state <= BIT_HIGH;
              cnt   <= '0;
            end
          end
          BIT_HIGH: begin
            // cnt trails the synced high width by one, hence >= rather than >
            if (fall) begin
              shift <= {shift[FRAME_W-2:0], (cnt >= CNT_W'(THR_CYC))};
              cnt   <= '0;
              if (bit_idx == 6'd0) begin
                state <= CHECK;
              end else begin
                bit_idx <= bit_idx - 6'd1;
                state   <= BIT_LOW;
              end
            end
          end
          CHECK: begin
            if (frame_sum(shift) == shift[CKS_MSB:CKS_LSB]) begin
              dht_data   <= shift;
              data_valid <= 1'b1;
            end else begin
              checksum_err <= 1'b1;
            end
            state <= HOLDOFF;
            cnt   <= '0;
          end
          HOLDOFF: begin
            if (cnt == CNT_W'(HOLD_CYC - 1)) begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
            end
          end
          default: begin
            state         <= IDLE;
            dht_drive_low <= 1'b0;
            busy          <= 1'b0;
            cnt           <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dht22_frame_rx.sv
// Bench for dht22_frame_rx: a timed sensor model drives the pin, expected
// pulses are queued at stimulus time and checked by an independent monitor.
module tb_dht22_frame_rx;

  localparam int START = 20;
  localparam int HOLD  = 100;
  localparam int TMO   = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        trigger = 1'b0;
  logic        sens_line = 1'b1;
  logic        dht_in;
  logic        dht_drive_low;
  logic [39:0] dht_data;
  logic        data_valid;
  logic        checksum_err;
  logic        timeout_err;
  logic        busy;

  assign dht_in = dht_drive_low ? 1'b0 : sens_line;

  dht22_frame_rx #(
    .CYC_PER_US   (1),
    .START_LOW_US (START),
    .BIT_THRESH_US(50),
    .TIMEOUT_US   (TMO),
    .HOLDOFF_US   (HOLD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .trigger      (trigger),
    .dht_in       (dht_in),
    .dht_drive_low(dht_drive_low),
    .dht_data     (dht_data),
    .data_valid   (data_valid),
    .checksum_err (checksum_err),
    .timeout_err  (timeout_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  typedef struct {
    int          kind;   // 0 valid, 1 checksum error, 2 timeout
    logic [39:0] data;
    int          delay;  // cycles from release to timeout pulse, -1 = any
  } exp_t;

  exp_t        sb[$];
  logic [39:0] last_good = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit cks_ok(input logic [39:0] f);
    int s;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return (s % 256) == int'(f[7:0]);
  endfunction

  function automatic logic [39:0] mk_good();
    logic [31:0] d;
    int s;
    d = $urandom;
    s = int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]) + int'(d[7:0]);
    return {d, 8'(s % 256)};
  endfunction

  task automatic push_frame(input logic [39:0] f);
    exp_t e;
    if (cks_ok(f)) begin
      last_good = f;
      e = '{0, f, -1};
    end else begin
      e = '{1, last_good, -1};
    end
    sb.push_back(e);
  endtask

  task automatic push_tmo(input int delay);
    exp_t e;
    e = '{2, last_good, delay};
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per output pulse.
  logic busy_prev = 1'b0;
  logic dl_prev = 1'b0;
  logic any_prev = 1'b0;
  int   rel_cyc = 0;
  int   pulse_cyc = -1;
  int   mon_n;
  int   mon_kind;
  exp_t mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      busy_prev = 1'b0;
      dl_prev   = 1'b0;
      any_prev  = 1'b0;
      pulse_cyc = -1;
    end else begin
      mon_n = int'(data_valid) + int'(checksum_err) + int'(timeout_err);
      if (dl_prev && !dht_drive_low) rel_cyc = cyc;
      if (mon_n != 0) begin
        chk("pulse_exclusive", mon_n, 1);
        chk("pulse_one_cycle", any_prev, 0);
        mon_kind = data_valid ? 0 : (checksum_err ? 1 : 2);
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got kind %0d expected no pulse", mon_kind);
        end else begin
          mon_e = sb.pop_front();
          chk("pulse_kind", mon_kind, mon_e.kind);
          chk("dht_data", dht_data, mon_e.data);
          if (mon_e.delay >= 0) chk("timeout_delay", cyc - rel_cyc, mon_e.delay);
        end
        pulse_cyc = cyc;
      end
      if (busy_prev && !busy && pulse_cyc >= 0) begin
        chk("holdoff_len", cyc - pulse_cyc, HOLD);
        pulse_cyc = -1;
      end
      busy_prev = busy;
      dl_prev   = dht_drive_low;
      any_prev  = (mon_n != 0);
    end
  end

  task automatic seg(input logic v, input int n);
    sens_line = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_xact(input bit keep, output int low_cyc);
    int w;
    low_cyc = 0;
    w = 0;
    trigger = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) trigger = 1'b0;
    while (!dht_drive_low && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    while (dht_drive_low && low_cyc < 1000) begin
      low_cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  // Sensor model; bnd selects exact 50/51 high widths, abort_bit resets mid-bit.
  task automatic send(input logic [39:0] f, input int nbits, input bit bnd, input int abort_bit);
    bit b;
    int hw;
    seg(1'b1, 30);
    seg(1'b0, 80);
    seg(1'b1, 80);
    for (int i = 0; i < nbits; i++) begin
      b = f[39-i];
      if (i == abort_bit) begin
        seg(1'b0, 10);
        #2 reset = 1'b0;
        #1;
        chk("reset_async_drive", dht_drive_low, 0);
        chk("reset_async_busy", busy, 0);
        chk("reset_async_data", dht_data, 0);
        chk("reset_async_pulses", {data_valid, checksum_err, timeout_err}, 0);
        sens_line = 1'b1;
        return;
      end
      if (bnd) hw = b ? 51 : 50;
      else     hw = b ? int'($urandom_range(60, 80)) : int'($urandom_range(20, 35));
      seg(1'b0, int'($urandom_range(40, 60)));
      seg(1'b1, hw);
    end
    seg(1'b0, 50);
    sens_line = 1'b1;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy && w < 3000) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("idle_reached", busy, 0);
  endtask

  initial begin
    logic [39:0] f;
    int lowc;
    int n;
    int seen;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {dht_drive_low, busy, data_valid, checksum_err, timeout_err}, 0);
    chk("reset_data", dht_data, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Start pulse length, then a good frame
    start_xact(1'b0, lowc);
    chk("start_low_len", lowc, START);
    chk("busy_after_start", busy, 1);
    f = 40'h028C015FEE;
    push_frame(f);
    send(f, 40, 1'b0, -1);
    wait_idle();

    // Bad checksum keeps previous frame
    start_xact(1'b0, lowc);
    f = 40'h028C015FEF;
    push_frame(f);
    send(f, 40, 1'b0, -1);
    wait_idle();

    // No response at all
    start_xact(1'b0, lowc);
    push_tmo(TMO);
    wait_idle();

    // Sensor stops after 17 bits, then a good frame
    start_xact(1'b0, lowc);
    push_tmo(-1);
    send(mk_good(), 17, 1'b0, -1);
    wait_idle();
    start_xact(1'b0, lowc);
    f = mk_good();
    push_frame(f);
    send(f, 40, 1'b0, -1);
    wait_idle();

    // Boundary widths with trigger held through HOLDOFF
    f = 40'h0000000101;
    start_xact(1'b1, lowc);
    push_frame(f);
    push_tmo(TMO);
    send(f, 40, 1'b1, -1);
    n = 0;
    while (busy && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    n = 0;
    while (!busy && n < 10) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk("retrigger_gap", n, 1);
    trigger = 1'b0;
    wait_idle();
    seen = 0;
    repeat (300) begin
      @(posedge clk);
      #1;
      if (busy) seen++;
    end
    chk("no_queued_trigger", seen, 0);

    // Async reset during bit 20, then a clean read
    start_xact(1'b0, lowc);
    send(mk_good(), 40, 1'b0, 20);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    last_good = '0;
    chk("sb_empty_after_abort", sb.size(), 0);
    @(posedge clk);
    #1;
    start_xact(1'b0, lowc);
    chk("start_low_after_reset", lowc, START);
    f = mk_good();
    push_frame(f);
    send(f, 40, 1'b0, -1);
    wait_idle();

    // Randomized frames, some with corrupted checksum
    for (int k = 0; k < 4; k++) begin
      f = mk_good();
      if ($urandom_range(0, 2) == 0) f[7:0] = f[7:0] ^ 8'(1 + $urandom_range(0, 254));
      start_xact(1'b0, lowc);
      push_frame(f);
      send(f, 40, 1'b0, -1);
      wait_idle();
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dht22_frame_rx.md
Name: dht22_frame_rx

Overview:
Single-wire DHT22 frame receiver. It issues the host start pulse, times the sensor's response and 40 data pulses, checks the checksum, and holds the last good 40-bit frame for the memory block's sensor read port. It sits between the board-level inout DHT pin and memory's dht_data input. Pin tristating stays at board level: this block only requests drive-low.

Parameters:
CYC_PER_US, 1, clk cycles per microsecond; all timings below are scaled by this.
START_LOW_US, 1000, host start-pulse low time.
BIT_THRESH_US, 50, high-pulse width threshold; width > threshold decodes as 1.
TIMEOUT_US, 200, maximum wait in any sensor-driven phase.
HOLDOFF_US, 2000000, minimum time from end of one transaction to the next start.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
trigger  in  1  request a read; level or pulse, sampled in IDLE only
dht_in  in  1  raw pin level (asynchronous)
dht_drive_low  out  1  1 = top drives pin 0; 0 = pin released (Z, pulled up)
dht_data  out  40  last checksum-valid frame, {RH[15:0], T[15:0], CKS[7:0]}
data_valid  out  1  one-cycle pulse when dht_data updates
checksum_err  out  1  one-cycle pulse on checksum mismatch
timeout_err  out  1  one-cycle pulse on phase timeout
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, async): state IDLE; dht_drive_low=0; dht_data=0; all pulses 0; busy=0; counters 0; synchronizer flops preset to 1.
- dht_in passes through a 2-flop synchronizer. Edge detection uses the synced value and its previous copy. There is 2 cycles of input latency; all timing is measured on the synced signal.
- A single cycle counter with width $clog2(max(START_LOW, HOLDOFF)*CYC_PER_US)+1 clears on every state entry.
- IDLE: trigger=1 -> START_LOW.
- START_LOW: dht_drive_low=1 for START_LOW_US*CYC_PER_US cycles -> RELEASE, with drive deasserted the same cycle.
- RELEASE: wait for synced falling edge -> RESP_LOW.
- RESP_LOW: wait for rising edge -> RESP_HIGH.
- RESP_HIGH: wait for falling edge -> BIT_LOW. Bit index = 39.
- BIT_LOW: wait for rising edge -> BIT_HIGH.
- BIT_HIGH: count cycles until falling edge, then decode:
  - bit = (count > BIT_THRESH_US*CYC_PER_US); equal decodes as 0.
  - Shift the bit in MSB-first; the first bit lands at shift[39].
  - If index = 0 -> CHECK, else decrement index -> BIT_LOW.
- CHECK (1 cycle): compute (s[39:32]+s[31:24]+s[23:16]+s[15:8]) mod 256.
  - Equal to s[7:0]: dht_data<=shift, data_valid=1.
  - Otherwise: checksum_err=1 and dht_data is unchanged.
  - Either way -> HOLDOFF.
- Timeout: in RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW or BIT_HIGH, count reaching TIMEOUT_US*CYC_PER_US triggers:
  - timeout_err=1 for 1 cycle, partial shift discarded, dht_data unchanged -> HOLDOFF.
- HOLDOFF: wait HOLDOFF_US*CYC_PER_US cycles -> IDLE. Triggers here are ignored and not queued.
- trigger while busy is ignored.
- dht_drive_low is high only in START_LOW; it is never asserted while the sensor drives the line.
- Pulses are mutually exclusive and registered; each is high exactly one cycle.
- Glitch-free pin edges are assumed to come from the synchronizer only; no extra debounce.
- Async reset mid-transaction returns to IDLE immediately and releases the pin the same instant.
- Outputs are registered (Moore), except that the pulses are asserted the cycle after the deciding edge.

Decomposition:
- Shared package dht_pkg holds:
  - the state enum (IDLE, START_LOW, RELEASE, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, HOLDOFF);
  - the frame width constant 40;
  - the field slice constants for RH, T and CKS.
- Sub-module sync_2ff (1-bit, reset value parameterised) is used for dht_in and is reusable elsewhere on board.

Test Plan:
All scenarios use CYC_PER_US=1, START_LOW_US=20, BIT_THRESH_US=50, TIMEOUT_US=200, HOLDOFF_US=100, and a behavioural sensor model (response 80 low/80 high, bit = 50 low + 27 high for 0 / 70 high for 1).
1. Reset, then trigger for 1 cycle -> dht_drive_low high exactly 20 cycles, then 0; busy stays 1.
2. Model sends 0x02_8C_01_5F_EE -> single data_valid pulse, dht_data=40'h028C015FEE, checksum_err and timeout_err never asserted, busy falls 100 cycles after CHECK.
3. Model sends 0x02_8C_01_5F_EF -> checksum_err pulse, dht_data holds 40'h028C015FEE from scenario 2, no data_valid.
4. Model never responds after release -> timeout_err pulse 200 cycles after entering RELEASE, dht_data unchanged; model stops after 17 bits -> timeout_err, next good frame decodes correctly.
5. Boundary widths: high pulse of 50 cycles decodes 0, 51 cycles decodes 1 (frame 0x00_00_00_01_01 with last data-byte bit at 51 -> valid); trigger held high through HOLDOFF starts exactly one new transaction, on the cycle after IDLE is re-entered.
6. Assert reset during bit 20 of a frame -> outputs return to reset values asynchronously, dht_drive_low=0, next trigger performs a clean full read.
